// File: rtl/g_sertx.sv
// g_sertx: active-low-handshake serial transmitter; frame = start(0), WIDTH data bits LSB first, optional parity, stop bit(s) (1).
// Latency: SO drops on the load edge; RDYN returns low CLKDIV*(1+WIDTH+(PARITY!=0)+STOP_BITS) cycles after that edge.
// Backpressure: LDN is honoured only in IDLE (RDYN=0); requests made while a frame is on SO are dropped, never queued.
module g_sertx #(
  parameter int WIDTH     = 8,
  parameter int CLKDIV    = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             CK,
  input  logic             CDN,
  input  logic [WIDTH-1:0] D,
  input  logic             LDN,
  output logic             RDYN,
  output logic             BSYN,
  output logic             SO
);

  // Divider is wide enough for 0..CLKDIV-1; bit counter covers data index and stop-bit index.
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(WIDTH + 2);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);

  // Reject parameter sets the frame format cannot represent.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("g_sertx: WIDTH must be in 1..16");
  end
  if (CLKDIV < 1) begin : g_bad_clkdiv
    $error("g_sertx: CLKDIV must be >= 1");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("g_sertx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("g_sertx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;

  // Frame sequencer: every non-idle slot lasts CLKDIV cycles; SO, RDYN and BSYN are updated on the slot boundary.
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      SO      <= 1'b1;
      RDYN    <= 1'b0;
      BSYN    <= 1'b1;
    end else if (state == S_IDLE) begin
      if (!LDN) begin
        // Parity is taken from the captured word so later D changes cannot leak into the frame.
        shreg   <= D;
        par_bit <= (^D) ^ PAR_ODD;
        div_cnt <= '0;
        bit_cnt <= '0;
        SO      <= 1'b0;
        RDYN    <= 1'b1;
        BSYN    <= 1'b0;
        state   <= S_START;
      end
    end else if (div_cnt != DIV_LAST) begin
      div_cnt <= div_cnt + DW'(1);
    end else begin
      div_cnt <= '0;
      case (state)
        S_START: begin
          SO      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (bit_cnt != DATA_LAST) begin
            SO      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BW'(1);
          end else if (PARITY != 0) begin
            SO    <= par_bit;
            state <= S_PARITY;
          end else begin
            SO      <= 1'b1;
            bit_cnt <= '0;
            state   <= S_STOP;
          end
        end
        S_PARITY: begin
          SO      <= 1'b1;
          bit_cnt <= '0;
          state   <= S_STOP;
        end
        S_STOP: begin
          if (bit_cnt != STOP_LAST) begin
            bit_cnt <= bit_cnt + BW'(1);
          end else begin
            bit_cnt <= '0;
            RDYN    <= 1'b0;
            BSYN    <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          SO    <= 1'b1;
          RDYN  <= 1'b0;
          BSYN  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g_sertx.sv
// Bench for g_sertx: five instances with different parameter sets share CK/CDN.
// Stimulus pushes hand-computed frames {stop.., parity?, data, start} into per-instance queues;
// a per-instance monitor captures each frame from SO/RDYN/BSYN and compares against the queue head.
module tb_g_sertx;

  localparam int N = 5;

  // Instance k parameters: 0..2 CLKDIV=4 with PARITY 0/1/2, 3 CLKDIV=1, 4 CLKDIV=2 with two stop bits.
  function automatic int cd_of(input int k);
    case (k)
      3:       return 1;
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int par_of(input int k);
    case (k)
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int k);
    return (k == 4) ? 2 : 1;
  endfunction

  typedef struct {
    logic [11:0] slots;
    int          n;
    int          gap;
  } exp_t;

  logic         CK     = 1'b0;
  logic         CDN    = 1'b1;
  logic         ck_run = 1'b0;
  logic [7:0]   d_a [N];
  logic [N-1:0] ldn;
  logic [N-1:0] so_v;
  logic [N-1:0] rdyn_v;
  logic [N-1:0] bsyn_v;
  exp_t         exp_q [N][$];
  int           tests   = 0;
  int           fails   = 0;
  int           rst_cnt = 0;

  initial forever begin
    #5;
    if (ck_run) CK = ~CK;
  end

  always @(negedge CDN) rst_cnt = rst_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input int k, input logic [11:0] s, input int n, input int gap);
    exp_t e;
    e.slots = s;
    e.n     = n;
    e.gap   = gap;
    exp_q[k].push_back(e);
  endtask

  task automatic load(input int k, input logic [7:0] d);
    @(negedge CK);
    d_a[k]  = d;
    ldn[k]  = 1'b0;
    @(negedge CK);
    ldn[k]  = 1'b1;
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    @(negedge CK);
    while (!(rdyn_v[k] === 1'b0 && bsyn_v[k] === 1'b1) && t < 2000) begin
      @(negedge CK);
      t++;
    end
    if (t >= 2000) begin
      tests++;
      fails++;
      $display("FAIL wait_done inst%0d: still busy after %0d cycles, expected idle", k, t);
    end
  endtask

  for (genvar k = 0; k < N; k++) begin : g_inst
    localparam int CDK = cd_of(k);

    g_sertx #(
      .WIDTH(8),
      .CLKDIV(CDK),
      .PARITY(par_of(k)),
      .STOP_BITS(stop_of(k))
    ) u_dut (
      .CK(CK),
      .CDN(CDN),
      .D(d_a[k]),
      .LDN(ldn[k]),
      .RDYN(rdyn_v[k]),
      .BSYN(bsyn_v[k]),
      .SO(so_v[k])
    );

    // Monitor: a frame is the run of cycles with BSYN low; frames cut short by CDN are discarded.
    initial begin : mon
      int          idle;
      int          cyc;
      int          rdy_hi;
      int          r0;
      logic        hist [$];
      logic [11:0] obs;
      logic        uni;
      exp_t        e;
      idle = 0;
      forever begin
        @(negedge CK);
        if (CDN !== 1'b1) begin
          idle = 0;
        end else if (bsyn_v[k] !== 1'b0) begin
          idle++;
        end else begin
          r0     = rst_cnt;
          cyc    = 0;
          rdy_hi = 0;
          hist.delete();
          while (bsyn_v[k] === 1'b0 && cyc < 4000) begin
            hist.push_back(so_v[k]);
            if (rdyn_v[k] === 1'b1) rdy_hi++;
            cyc++;
            @(negedge CK);
          end
          if (rst_cnt != r0) begin
            idle = 0;
          end else if (exp_q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL inst%0d unexpected frame: got %0d-cycle frame, expected none", k, cyc);
            idle = 1;
          end else begin
            e   = exp_q[k].pop_front();
            obs = '0;
            uni = 1'b1;
            for (int s = 0; s < e.n && s < 12; s++) begin
              obs[s] = (s * CDK < hist.size()) ? hist[s * CDK] : 1'bx;
            end
            for (int j = 0; j < hist.size(); j++) begin
              if (hist[j] !== hist[(j / CDK) * CDK]) uni = 1'b0;
            end
            check($sformatf("inst%0d frame_len", k), cyc, e.n * CDK);
            check($sformatf("inst%0d rdyn_high_cycles", k), rdy_hi, e.n * CDK);
            check($sformatf("inst%0d rdyn_after_frame", k), {31'd0, rdyn_v[k]}, 32'd0);
            check($sformatf("inst%0d slot_bits", k), {20'd0, obs}, {20'd0, e.slots});
            check($sformatf("inst%0d slot_stable", k), {31'd0, uni}, 32'd1);
            if (e.gap >= 0) check($sformatf("inst%0d idle_gap", k), idle, e.gap);
            idle = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int t;
    ldn = '1;
    for (int k = 0; k < N; k++) d_a[k] = 8'h00;

    // Clear with the clock stopped: outputs must settle with no edge.
    #2 CDN = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("inst%0d reset SO", k), {31'd0, so_v[k]}, 32'd1);
      check($sformatf("inst%0d reset RDYN", k), {31'd0, rdyn_v[k]}, 32'd0);
      check($sformatf("inst%0d reset BSYN", k), {31'd0, bsyn_v[k]}, 32'd1);
    end
    #2 CDN = 1'b1;
    #1 ck_run = 1'b1;
    repeat (3) @(negedge CK);

    // A5 = 1010_0101, four ones: even parity 0, odd parity 1.
    expect_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1);
    load(0, 8'hA5);
    wait_done(0);
    expect_frame(1, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1);
    load(1, 8'hA5);
    wait_done(1);
    expect_frame(2, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1);
    load(2, 8'hA5);
    wait_done(2);
    // 01 has one set bit: even parity 1.
    expect_frame(1, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, -1);
    load(1, 8'h01);
    wait_done(1);
    // Two stop bits at CLKDIV=2: 11 slots, 22 cycles.
    expect_frame(4, {1'b0, 2'b11, 8'h81, 1'b0}, 11, -1);
    load(4, 8'h81);
    wait_done(4);

    // LDN held low at CLKDIV=1: second frame carries the D present at the second load edge, one idle cycle between.
    expect_frame(3, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, -1);
    expect_frame(3, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 1);
    @(negedge CK);
    d_a[3] = 8'h3C;
    ldn[3] = 1'b0;
    @(negedge CK);
    d_a[3] = 8'hC3;
    t = 0;
    while (rdyn_v[3] !== 1'b0 && t < 100) begin
      @(negedge CK);
      t++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL inst3 first frame end: RDYN still %b after %0d cycles, expected 0", rdyn_v[3], t);
    end
    @(negedge CK);
    ldn[3] = 1'b1;
    wait_done(3);

    // Load request during DATA must be dropped; only one frame may appear.
    expect_frame(0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, -1);
    load(0, 8'hFF);
    repeat (10) @(negedge CK);
    ldn[0] = 1'b0;
    @(negedge CK);
    ldn[0] = 1'b1;
    wait_done(0);
    repeat (5) @(negedge CK);

    // Clear during the third data bit of 00, then a clean 55 frame.
    load(0, 8'h00);
    repeat (13) @(negedge CK);
    check("abort pre SO", {31'd0, so_v[0]}, 32'd0);
    check("abort pre BSYN", {31'd0, bsyn_v[0]}, 32'd0);
    #1 CDN = 1'b0;
    #1;
    check("abort SO", {31'd0, so_v[0]}, 32'd1);
    check("abort RDYN", {31'd0, rdyn_v[0]}, 32'd0);
    check("abort BSYN", {31'd0, bsyn_v[0]}, 32'd1);
    #1 CDN = 1'b1;
    repeat (2) @(negedge CK);
    check("post abort SO", {31'd0, so_v[0]}, 32'd1);
    check("post abort BSYN", {31'd0, bsyn_v[0]}, 32'd1);
    expect_frame(0, {2'b00, 1'b1, 8'h55, 1'b0}, 10, -1);
    load(0, 8'h55);
    wait_done(0);

    // Drain long enough for any stray frame to complete, then every queued frame must have been seen.
    repeat (100) @(negedge CK);
    for (int k = 0; k < N; k++) begin
      check($sformatf("inst%0d frames_outstanding", k), exp_q[k].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/g_sertx.md
Name: g_sertx

Overview:
- Schematic-capture behaviour macro: an active-low-handshake serial transmitter. It serialises a parallel word onto a single idle-high line as start bit, data (LSB first), optional parity bit, and stop bit(s).
- It is the driving end of the active-low serial links that the combinational active-low gate macros (G_2NOR2 family) qualify and combine on the receive side.
- It sits between a parallel data source and a pad or line driver.

Parameters:
WIDTH, 8, data bits per frame (1..16)
CLKDIV, 16, CK cycles per bit time (>=1)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
CK  input  1  clock; all state changes on the rising edge
CDN  input  1  asynchronous active-low clear
D  input  WIDTH  parallel data, sampled at the load edge
LDN  input  1  active-low load request
RDYN  output  1  active-low ready; 0 means a load will be accepted
BSYN  output  1  active-low busy; 0 while a frame is on SO
SO  output  1  serial out; idle and stop = 1, start = 0

Behaviour:
- Interface: one clock (CK); reset CDN is asynchronous and active-low. All outputs are registered.
- Reset (CDN=0), effective immediately and independent of CK: SO=1, RDYN=0, BSYN=1, state=IDLE, bit counter=0, divider=0, shift register=0.
- Reset mid-frame aborts the frame. SO returns to 1 at once. No partial frame resumes after CDN deasserts.
- State machine: IDLE -> START -> DATA -> PARITY (only when PARITY!=0) -> STOP -> IDLE.
- Load handshake:
  - Accepted at a rising CK edge with state=IDLE and LDN=0 (RDYN=0 is the indication).
  - On that edge: D is captured, SO=0, RDYN=1, BSYN=0, state=START.
  - LDN is ignored whenever state!=IDLE. No queuing.
  - D changes after the load edge do not affect the frame.
- Bit timing:
  - Each of START, every DATA bit, PARITY, and every stop bit holds SO for exactly CLKDIV cycles.
  - The divider counts 0..CLKDIV-1. The bit advances on the edge where divider=CLKDIV-1.
  - CLKDIV=1 gives one bit per cycle.
- DATA: bit i (i=0..WIDTH-1, LSB first) is driven in the i-th data slot.
- Parity:
  - PARITY=1: parity bit = XOR of the WIDTH data bits.
  - PARITY=2: parity bit = inverse of that XOR.
  - Computed from the captured word.
- STOP: SO=1 for STOP_BITS*CLKDIV cycles. On the edge ending the last stop bit: state=IDLE, RDYN=0, BSYN=1.
- Frame length from load edge to RDYN falling = CLKDIV*(1+WIDTH+(PARITY!=0)+STOP_BITS) cycles.
- Back-to-back: the earliest next load is the first edge at which RDYN=0 is sampled. This gives exactly 1 idle CK cycle (SO=1) between the last stop bit and the next start bit.
- LDN held low continuously: frames repeat with that 1-cycle gap.
- Illegal parameters (CLKDIV=0, PARITY=3, STOP_BITS not 1/2): the model issues an elaboration-time error.

Test Plan:
- CDN pulsed low while idle and while CK is stopped -> SO=1, RDYN=0, BSYN=1 immediately with no clock edge.
- WIDTH=8, CLKDIV=4, PARITY=0, STOP_BITS=1, D=8'hA5, LDN low 1 cycle:
  - SO per 4-cycle slot = 0,1,0,1,0,0,1,0,1,1.
  - RDYN=1 for 40 cycles; BSYN=0 for the same 40 cycles.
- Same frame with PARITY=1 -> parity slot SO=0, frame 44 cycles. PARITY=2 -> parity slot SO=1. D=8'h01 with PARITY=1 -> parity slot SO=1.
- LDN held low, D=8'h3C then 8'hC3, CLKDIV=1 -> two frames of 10 cycles each separated by exactly 1 idle cycle. Second frame carries 8'hC3 (the D value at the second load edge).
- LDN pulsed low during the DATA state of a frame with D=8'hFF -> ignored; the current frame completes unchanged and no second frame follows.
- CDN asserted during the 3rd data bit of 8'h00 -> SO=1 asynchronously and RDYN=0. After release, a load of 8'h55 produces a clean full frame.
